serial_pattern_tx: RTL

Serial bit-pattern transmitter: it captures a parallel pattern of 1 to WIDTH bits on a start strobe and drives it out one bit per clock on a single serial line. It is the source end of the single-bit serial input `w` that the lab sequence detectors consume, so a detector can be driven directly from a loaded pattern rather than toggled by hand. A done pulse marks the end of each transfer. An optional repeat mode streams the pattern back-to-back.

---
 rtl/serial_pattern_tx_if.sv | 34 +++
 rtl/serial_pattern_tx.sv | 83 ++++++++
 2 files changed

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - request/serial-output bundle for serial_pattern_tx; SEQ_TX_REPEAT_EN adds repeat_mode
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] length;
`ifdef SEQ_TX_REPEAT_EN
  logic             repeat_mode;
`endif
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] bits_left;
  logic [1:0]       state;

  modport master (
`ifdef SEQ_TX_REPEAT_EN
    output repeat_mode,
`endif
    output start, pattern, length,
    input  w, w_valid, busy, done, bits_left, state
  );

  modport slave (
`ifdef SEQ_TX_REPEAT_EN
    input  repeat_mode,
`endif
    input  start, pattern, length,
    output w, w_valid, busy, done, bits_left, state
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - parallel-load, MSB-first serial pattern transmitter
// Optional back-to-back repeat streaming is enabled by defining SEQ_TX_REPEAT_EN.
module serial_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input logic               clock,
  input logic               resetn,
  serial_pattern_tx_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_q;
  logic [WIDTH-1:0] shreg;
  logic [LEN_W-1:0] cnt;
  logic             len_ok;

`ifdef SEQ_TX_REPEAT_EN
  logic [WIDTH-1:0] shadow;
  logic [LEN_W-1:0] len_cap;
`endif

  assign len_ok = (bus.length != '0) && (bus.length <= WIDTH_L);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      shreg   <= '0;
      cnt     <= '0;
`ifdef SEQ_TX_REPEAT_EN
      shadow  <= '0;
      len_cap <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start && len_ok) begin
            // Left-align so the first bit to send always sits in the MSB.
            shreg   <= bus.pattern << (WIDTH_L - bus.length);
            cnt     <= bus.length;
            state_q <= SEND;
`ifdef SEQ_TX_REPEAT_EN
            shadow  <= bus.pattern << (WIDTH_L - bus.length);
            len_cap <= bus.length;
`endif
          end
        end
        SEND: begin
          shreg <= shreg << 1;
          cnt   <= cnt - ONE_L;
          if (cnt == ONE_L) begin
`ifdef SEQ_TX_REPEAT_EN
            if (bus.repeat_mode) begin
              shreg <= shadow;
              cnt   <= len_cap;
            end else begin
              state_q <= DONE;
            end
`else
            state_q <= DONE;
`endif
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.w         = (state_q == SEND) ? shreg[WIDTH-1] : 1'b0;
  assign bus.w_valid   = (state_q == SEND);
  assign bus.busy      = (state_q == SEND) || (state_q == DONE);
  assign bus.done      = (state_q == DONE);
  assign bus.bits_left = (state_q == SEND) ? cnt : '0;
  assign bus.state     = state_q;
endmodule
